// File: rtl/token_run_packer.sv
// Measures runs of consecutive '1' tokens on a serial stream and queues {len, sat}
// records in a small FIFO drained over a valid/ready handshake.
module token_run_packer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_len,
  output logic                     out_sat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CNT_W-1:0] len;
    logic             sat;
  } rec_t;

  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
  logic             run_sat, run_sat_nxt;
  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [LVL_W-1:0] level_nxt, level_after_pop;
  rec_t             head_nxt, push_rec;
  logic             drop_nxt;
  logic             push_req, pop, push_ok, full;

  // Run counter: saturates at CNT_MAX and flags any further '1' tokens.
  always_comb begin
    run_cnt_nxt = run_cnt;
    run_sat_nxt = run_sat;
    push_req    = 1'b0;
    if (a) begin
      if (run_cnt == CNT_MAX) begin
        run_sat_nxt = 1'b1;
      end else begin
        run_cnt_nxt = run_cnt + CNT_W'(1);
      end
    end else if (run_cnt != '0) begin
      push_req    = 1'b1;
      run_cnt_nxt = '0;
      run_sat_nxt = 1'b0;
    end
  end

  // FIFO control: a same-cycle pop frees a slot for the push.
  always_comb begin
    push_rec.len    = run_cnt;
    push_rec.sat    = run_sat;
    pop             = out_valid && out_ready;
    full            = (level == LVL_W'(DEPTH));
    push_ok         = push_req && (!full || pop);
    drop_nxt        = drop || (push_req && !push_ok);
    level_after_pop = level - LVL_W'(pop);
    level_nxt       = level_after_pop + LVL_W'(push_ok);
    rd_ptr_nxt      = rd_ptr + PTR_W'(pop);
    wr_ptr_nxt      = wr_ptr + PTR_W'(push_ok);
    head_nxt        = '0;
    if (level_nxt != '0) begin
      // Entry being written now becomes head when nothing older remains.
      if (level_after_pop == '0) begin
        head_nxt = push_rec;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt   <= '0;
      run_sat   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_len   <= '0;
      out_sat   <= 1'b0;
    end else begin
      run_cnt   <= run_cnt_nxt;
      run_sat   <= run_sat_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      drop      <= drop_nxt;
      out_valid <= (level_nxt != '0);
      out_len   <= head_nxt.len;
      out_sat   <= head_nxt.sat;
    end
  end

  // Storage needs no reset: occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_rec;
    end
  end

endmodule

// File: tb/tb_token_run_packer.sv
// Bench for token_run_packer: directed vector table, corner sequences and a
// randomized run against a queue-based record model.
module tb_token_run_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_len;
  logic       out_sat;
  logic [2:0] level;
  logic       drop;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {sat,len}, unbounded run length, sticky drop.
  logic [8:0] mq[$];
  int         mrun;
  bit         mdrop;
  logic [8:0] got[$];

  token_run_packer #(.CNT_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .out_len(out_len), .out_sat(out_sat), .level(level), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       rdy;
    logic       v;
    logic [7:0] len;
    logic       sat;
    logic [2:0] lvl;
    logic       drp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mrun  = 0;
    mdrop = 0;
  endtask

  task automatic model_update(input logic ai, input logic ri);
    bit         push;
    logic [8:0] rec;
    push = !ai && (mrun > 0);
    rec  = {(mrun > 255) ? 1'b1 : 1'b0, (mrun > 255) ? 8'd255 : 8'(mrun)};
    if (mq.size() > 0 && ri) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 4) mq.push_back(rec);
      else mdrop = 1;
    end
    mrun = ai ? mrun + 1 : 0;
  endtask

  task automatic check_model();
    logic [8:0] h;
    h = (mq.size() > 0) ? mq[0] : 9'd0;
    chk("model_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
    chk("model_len", int'(out_len), int'(h[7:0]));
    chk("model_sat", int'(out_sat), int'(h[8]));
    chk("model_level", int'(level), mq.size());
    chk("model_drop", int'(drop), int'(mdrop));
  endtask

  // Inputs applied at negedge, outputs sampled 1 time unit later.
  task automatic step(input logic ai, input logic ri);
    a = ai;
    out_ready = ri;
    #1;
    check_model();
    if (out_valid && ri) got.push_back({out_sat, out_len});
    model_update(ai, ri);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    a = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({out_valid, out_len, out_sat, level, drop}), 0);
    rst = 1'b1;
    model_reset();
    got.delete();
  endtask

  task automatic run(input int n, input logic ri);
    for (int i = 0; i < n; i++) step(1'b1, ri);
    step(1'b0, ri);
  endtask

  initial begin
    rst = 1'b0;
    a = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // a=1,1,0 held, then drained; then a=1,0,1,1,1,0 with ready high.
    tbl[0]  = '{1, 0, 0, 8'd0, 0, 3'd0, 0};
    tbl[1]  = '{1, 0, 0, 8'd0, 0, 3'd0, 0};
    tbl[2]  = '{0, 0, 0, 8'd0, 0, 3'd0, 0};
    tbl[3]  = '{0, 0, 1, 8'd2, 0, 3'd1, 0};
    tbl[4]  = '{0, 1, 1, 8'd2, 0, 3'd1, 0};
    tbl[5]  = '{0, 1, 0, 8'd0, 0, 3'd0, 0};
    tbl[6]  = '{1, 1, 0, 8'd0, 0, 3'd0, 0};
    tbl[7]  = '{0, 1, 0, 8'd0, 0, 3'd0, 0};
    tbl[8]  = '{1, 1, 1, 8'd1, 0, 3'd1, 0};
    tbl[9]  = '{1, 1, 0, 8'd0, 0, 3'd0, 0};
    tbl[10] = '{1, 1, 0, 8'd0, 0, 3'd0, 0};
    tbl[11] = '{0, 1, 0, 8'd0, 0, 3'd0, 0};
    tbl[12] = '{0, 1, 1, 8'd3, 0, 3'd1, 0};
    tbl[13] = '{0, 1, 0, 8'd0, 0, 3'd0, 0};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      a = tbl[i].a;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          int'({out_valid, out_len, out_sat, level, drop}),
          int'({tbl[i].v, tbl[i].len, tbl[i].sat, tbl[i].lvl, tbl[i].drp}));
      model_update(tbl[i].a, tbl[i].rdy);
      @(negedge clk);
    end

    // Saturation: 300 ones then a run of 5.
    do_reset();
    run(300, 1'b1);
    run(5, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    chk("sat_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("sat_rec0", int'(got[0]), int'({1'b1, 8'd255}));
      chk("sat_rec1", int'(got[1]), int'({1'b0, 8'd5}));
    end

    // Exactly max length does not saturate.
    do_reset();
    run(255, 1'b1);
    step(1'b0, 1'b1);
    chk("max_no_sat", got.size() > 0 ? int'(got[0]) : -1, int'({1'b0, 8'd255}));

    // Overflow: five runs into a stalled FIFO, then drain.
    do_reset();
    for (int k = 1; k <= 5; k++) run(k, 1'b0);
    step(1'b0, 1'b0);
    chk("ovf_level", int'(level), 4);
    chk("ovf_drop", int'(drop), 1);
    repeat (5) step(1'b0, 1'b1);
    chk("ovf_drained", got.size(), 4);
    for (int k = 0; k < got.size() && k < 4; k++)
      chk($sformatf("ovf_len%0d", k), int'(got[k][7:0]), k + 1);
    chk("ovf_drop_sticky", int'(drop), 1);

    // Full FIFO, run ends in the same cycle as a pop.
    do_reset();
    for (int k = 1; k <= 4; k++) run(k, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("pp_level", int'(level), 4);
    chk("pp_drop", int'(drop), 0);
    repeat (5) step(1'b0, 1'b1);
    chk("pp_last", got.size() == 5 ? int'(got[4][7:0]) : -1, 2);

    // Asynchronous reset mid-run with records buffered.
    do_reset();
    run(2, 1'b0);
    run(3, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_rst", int'({out_valid, out_len, out_sat, level, drop}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    got.delete();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("post_rst_count", got.size(), 1);
    chk("post_rst_len", got.size() > 0 ? int'(got[0]) : -1, int'({1'b0, 8'd1}));

    // Randomized runs, gaps and back-pressure.
    do_reset();
    for (int r = 0; r < 80; r++) begin
      int len;
      int gap;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 262) : $urandom_range(1, 6);
      gap = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) step(1'b1, ($urandom % 3) != 0);
      for (int i = 0; i < gap; i++) step(1'b0, ($urandom % 3) != 0);
    end
    repeat (6) step(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
